// File: rtl/mos_pkg.sv
// Shared definitions for the fetch unit: address/data widths, FSM state
// encoding and the {byte, address} entry carried through the prefetch queue.
// Pure package: no logic, no latency, no flow control of its own.
package mos_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_FLUSHED = 2'd0,
      ST_REQUEST = 2'd1,
      ST_FULL    = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic [ADDR_W-1:0] addr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {byte, address} entries; head is presented combinationally.
// Latency: a pushed entry is visible at the head one cycle later (if queue was empty).
// Backpressure: push is dropped when full unless a pop happens in the same cycle;
// pop on empty is ignored; i_flush empties the queue and overrides push/pop.
// Ports: clk_2/rst (sync, active-high), i_push/i_push_dat, i_pop, i_flush,
//        o_count (occupancy 0..DEPTH), o_head (entry at the read pointer).
module fetch_fifo
   import mos_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk_2,
   input  logic              rst,
   input  logic              i_push,
   input  fetch_entry_t      i_push_dat,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic [CNT_W-1:0]  o_count,
   output fetch_entry_t      o_head
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   fetch_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   assign w_pop  = i_pop && (r_count != '0) && !i_flush;
   // A full queue can still accept a byte when the head leaves in the same cycle.
   assign w_push = i_push && !i_flush && ((r_count != CNT_FULL) || w_pop);

   always_ff @(posedge clk_2) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage is not reset: entries are only observed while count is non-zero.
   always_ff @(posedge clk_2) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Byte-wide instruction prefetcher: fetches sequential bytes into a DEPTH-entry queue.
// Latency: flush at n -> mem_req at n+2 -> head valid at n+3 with an immediate ack.
// Backpressure: stops requesting while the queue is full; one request outstanding max.
// Ports: clk_2, rst (sync, active-high); memory side mem_req/mem_addr/mem_ack/mem_data;
//        redirect flush/flush_pc; decoder side instruction/head_pc/valid/consume.
module instruction_fetch
   import mos_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk_2,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic [DATA_W-1:0] instruction,
   output logic              valid,
   input  logic              consume,
   output logic [ADDR_W-1:0] head_pc
);

   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_fpc;
   logic [ADDR_W-1:0] w_fpc_nxt;
   logic              w_req;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_head;
   fetch_entry_t      w_push_dat;

   always_ff @(posedge clk_2) begin
      if (rst) begin
         r_state <= ST_FLUSHED;
         r_fpc   <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_fpc   <= w_fpc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fpc_nxt   = r_fpc;
      w_req       = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_FLUSHED: w_state_nxt = ST_REQUEST;
         ST_REQUEST: begin
            w_req = 1'b1;
            if (mem_ack) begin
               w_push    = 1'b1;
               w_fpc_nxt = r_fpc + 1'b1;
               if ((w_count == CNT_LAST) && !w_pop) w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_count != CNT_FULL) w_state_nxt = ST_REQUEST;
         end
         default: w_state_nxt = ST_FLUSHED;
      endcase
      // Redirect beats everything: the acked byte and any pop this cycle are dropped.
      if (flush) begin
         w_state_nxt = ST_FLUSHED;
         w_fpc_nxt   = flush_pc;
         w_push      = 1'b0;
      end
   end

   // Outputs are forced to their reset view during the assertion cycle itself,
   // before the synchronous reset has had a chance to land in the registers.
   assign mem_req  = w_req && !rst;
   assign mem_addr = rst ? RESET_PC : r_fpc;
   assign valid    = (w_count != '0) && !rst;
   assign w_pop    = consume && valid;

   assign w_push_dat = '{dat: mem_data, addr: r_fpc};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_2      (clk_2),
      .rst        (rst),
      .i_push     (w_push && !rst),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (flush),
      .o_count    (w_count),
      .o_head     (w_head)
   );

   assign instruction = w_head.dat;
   assign head_pc     = w_head.addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (DEPTH=4, RESET_PC=0000).
// Memory model returns addr[7:0]; ack latency is programmable, or acks are hand-driven.
// Stimulus and sampling happen 1 time unit after each rising edge of clk_2.
module tb_instruction_fetch;

   logic        clk_2 = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic        flush;
   logic [15:0] flush_pc;
   logic [7:0]  instruction;
   logic        valid;
   logic        consume;
   logic [15:0] head_pc;

   int checks   = 0;
   int failures = 0;
   int ack_cnt  = 0;

   logic        mem_en   = 1'b0;
   int          mem_lat  = 0;
   int          wait_cnt = 0;
   logic        mdl_ack  = 1'b0;
   logic [7:0]  mdl_data = 8'h00;
   logic        man_ack  = 1'b0;
   logic [7:0]  man_data = 8'h00;

   assign mem_ack  = mem_en ? mdl_ack  : man_ack;
   assign mem_data = mem_en ? mdl_data : man_data;

   always #5 clk_2 = ~clk_2;

   instruction_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk_2       (clk_2),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .instruction (instruction),
      .valid       (valid),
      .consume     (consume),
      .head_pc     (head_pc)
   );

   // Memory: ack lands on the (mem_lat+1)-th cycle of each request.
   always @(negedge clk_2) begin
      if (!mem_req || !mem_en) begin
         mdl_ack  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (mdl_ack) wait_cnt = 0;
         if (wait_cnt >= mem_lat) begin
            mdl_ack = 1'b1;
         end else begin
            mdl_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
         end
      end
      mdl_data = mem_addr[7:0];
   end

   always @(posedge clk_2) if (mem_req === 1'b1 && mem_ack === 1'b1) ack_cnt++;

   task automatic tick;
      @(posedge clk_2);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; flush_pc = 16'h0000; consume = 1'b0;
      mem_en = 1'b1; mem_lat = 0; man_ack = 1'b0; man_data = 8'h00;
      repeat (3) tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      rst = 1'b0;
   endtask

   task automatic test_fill;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({mem_req, mem_addr} !== {1'b1, 16'(i)}) begin
            failures++; $display("FAIL fill_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, mem_req, mem_addr, 16'(i));
         end
         if (i == 1) begin
            checks++;
            if ({valid, instruction, head_pc} !== {1'b1, 8'h00, 16'h0000}) begin
               failures++; $display("FAIL first_valid got v=%b ins=%h pc=%h exp v=1 ins=00 pc=0000", valid, instruction, head_pc);
            end
         end
      end
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_no_req got=%b exp=0", mem_req); end
      repeat (3) tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_stays got=%b exp=0", mem_req); end
      checks++; if (ack_cnt !== 4) begin failures++; $display("FAIL full_ack_cnt got=%0d exp=4", ack_cnt); end
      checks++; if ({valid, instruction} !== {1'b1, 8'h00}) begin failures++; $display("FAIL full_head got v=%b ins=%h exp v=1 ins=00", valid, instruction); end
   endtask

   task automatic test_consume_one;
      consume = 1'b1; tick(); consume = 1'b0;
      checks++; if ({instruction, head_pc} !== {8'h01, 16'h0001}) begin failures++; $display("FAIL pop_head got ins=%h pc=%h exp ins=01 pc=0001", instruction, head_pc); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL pop_still_full got=%b exp=0", mem_req); end
      tick();
      checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0004}) begin failures++; $display("FAIL refetch got req=%b addr=%h exp req=1 addr=0004", mem_req, mem_addr); end
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL refull got=%b exp=0", mem_req); end
      repeat (2) tick();
      checks++; if (ack_cnt !== 5) begin failures++; $display("FAIL refetch_once got=%0d exp=5", ack_cnt); end
   endtask

   task automatic test_flush_wrap;
      logic [15:0] exp_pc [3];
      exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
      flush = 1'b1; flush_pc = 16'hFFFE; tick(); flush = 1'b0;
      checks++; if ({valid, mem_req} !== 2'b00) begin failures++; $display("FAIL flush_clear got v=%b req=%b exp 0 0", valid, mem_req); end
      tick();
      checks++; if ({mem_req, mem_addr} !== {1'b1, 16'hFFFE}) begin failures++; $display("FAIL flush_req got req=%b addr=%h exp req=1 addr=FFFE", mem_req, mem_addr); end
      tick();
      checks++; if ({valid, instruction, head_pc, mem_addr} !== {1'b1, 8'hFE, 16'hFFFE, 16'hFFFF}) begin
         failures++; $display("FAIL flush_first got v=%b ins=%h pc=%h addr=%h exp 1 FE FFFE FFFF", valid, instruction, head_pc, mem_addr);
      end
      tick();
      checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", mem_addr); end
      tick();
      checks++; if (mem_addr !== 16'h0001) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0001", mem_addr); end
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL wrap_full got=%b exp=0", mem_req); end
      consume = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({head_pc, instruction} !== {exp_pc[k], exp_pc[k][7:0]}) begin
            failures++; $display("FAIL wrap_head%0d got pc=%h ins=%h exp pc=%h", k, head_pc, instruction, exp_pc[k]);
         end
      end
      consume = 1'b0;
   endtask

   task automatic test_back_to_back_flush;
      flush = 1'b1; flush_pc = 16'h6000; tick();
      checks++; if ({mem_req, valid} !== 2'b00) begin failures++; $display("FAIL b2b_first got req=%b v=%b exp 0 0", mem_req, valid); end
      flush_pc = 16'h7000; tick(); flush = 1'b0;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b exp=0", mem_req); end
      tick();
      checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h7000}) begin failures++; $display("FAIL b2b_last_wins got req=%b addr=%h exp req=1 addr=7000", mem_req, mem_addr); end
   endtask

   task automatic test_pushpop_last;
      flush = 1'b1; flush_pc = 16'h5000; tick(); flush = 1'b0;
      repeat (4) tick();
      checks++; if ({mem_req, mem_addr, head_pc} !== {1'b1, 16'h5003, 16'h5000}) begin
         failures++; $display("FAIL pp3_setup got req=%b addr=%h pc=%h exp 1 5003 5000", mem_req, mem_addr, head_pc);
      end
      consume = 1'b1; tick();
      checks++; if ({mem_req, mem_addr, head_pc} !== {1'b1, 16'h5004, 16'h5001}) begin
         failures++; $display("FAIL pp3_same got req=%b addr=%h pc=%h exp 1 5004 5001", mem_req, mem_addr, head_pc);
      end
      tick(); consume = 1'b0;
      checks++; if ({mem_addr, head_pc} !== {16'h5005, 16'h5002}) begin failures++; $display("FAIL pp3_next got addr=%h pc=%h exp 5005 5002", mem_addr, head_pc); end
      tick();
      checks++; if ({mem_req, valid, head_pc} !== {1'b0, 1'b1, 16'h5002}) begin
         failures++; $display("FAIL pp3_full got req=%b v=%b pc=%h exp 0 1 5002", mem_req, valid, head_pc);
      end
   endtask

   task automatic test_pushpop_one;
      flush = 1'b1; flush_pc = 16'h4000; tick(); flush = 1'b0; consume = 1'b1;
      tick();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL pp1_empty got=%b exp=0", valid); end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({valid, head_pc, instruction} !== {1'b1, 16'(16'h4000 + k), 8'(k)}) begin
            failures++; $display("FAIL pp1_seq%0d got v=%b pc=%h ins=%h exp pc=%h", k, valid, head_pc, instruction, 16'(16'h4000 + k));
         end
         tick();
      end
      consume = 1'b0;
   endtask

   task automatic test_latency;
      logic        prev_req;
      logic [15:0] prev_addr;
      int          n;
      n = 0; prev_req = 1'b0; prev_addr = 16'h0000;
      mem_lat = 2;
      flush = 1'b1; flush_pc = 16'h0100; tick(); flush = 1'b0; consume = 1'b1;
      for (int j = 0; j < 45; j++) begin
         tick();
         if (mem_req && prev_req && !mem_ack) begin
            checks++;
            if (mem_addr !== prev_addr) begin failures++; $display("FAIL lat_addr_stable got=%h exp=%h", mem_addr, prev_addr); end
         end
         if (valid) begin
            checks++;
            if ({head_pc, instruction} !== {16'(16'h0100 + n), 8'(n)}) begin
               failures++; $display("FAIL lat_order%0d got pc=%h ins=%h exp pc=%h", n, head_pc, instruction, 16'(16'h0100 + n));
            end
            n++;
         end
         prev_req = mem_req; prev_addr = mem_addr;
      end
      consume = 1'b0; mem_lat = 0;
      checks++; if (n !== 14) begin failures++; $display("FAIL lat_count got=%0d exp=14", n); end
   endtask

   task automatic test_flush_ack_consume;
      flush = 1'b1; flush_pc = 16'h2000; tick(); flush = 1'b0;
      repeat (2) tick();
      checks++; if ({valid, head_pc} !== {1'b1, 16'h2000}) begin failures++; $display("FAIL fac_setup got v=%b pc=%h exp 1 2000", valid, head_pc); end
      mem_en = 1'b0; man_ack = 1'b1; man_data = 8'hAA; consume = 1'b1;
      flush = 1'b1; flush_pc = 16'h3000;
      tick();
      flush = 1'b0; consume = 1'b0; man_ack = 1'b0;
      checks++; if ({valid, mem_req} !== 2'b00) begin failures++; $display("FAIL fac_discard got v=%b req=%b exp 0 0", valid, mem_req); end
      tick();
      checks++; if ({mem_req, mem_addr, valid} !== {1'b1, 16'h3000, 1'b0}) begin
         failures++; $display("FAIL fac_redirect got req=%b addr=%h v=%b exp 1 3000 0", mem_req, mem_addr, valid);
      end
      man_ack = 1'b1; man_data = 8'h77; tick(); man_ack = 1'b0;
      checks++; if ({valid, instruction, head_pc} !== {1'b1, 8'h77, 16'h3000}) begin
         failures++; $display("FAIL fac_new_byte got v=%b ins=%h pc=%h exp 1 77 3000", valid, instruction, head_pc);
      end
   endtask

   task automatic test_rst_mid;
      rst = 1'b1; flush = 1'b1; flush_pc = 16'h9999; man_ack = 1'b1; man_data = 8'h55;
      tick();
      checks++; if ({mem_req, valid, mem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
         failures++; $display("FAIL rst_mid got req=%b v=%b addr=%h exp 0 0 0000", mem_req, valid, mem_addr);
      end
      rst = 1'b0; flush = 1'b0; man_ack = 1'b0;
      tick();
      checks++; if ({mem_req, mem_addr, valid} !== {1'b1, 16'h0000, 1'b0}) begin
         failures++; $display("FAIL rst_restart got req=%b addr=%h v=%b exp 1 0000 0", mem_req, mem_addr, valid);
      end
   endtask

   task automatic test_consume_empty;
      consume = 1'b1; repeat (2) tick(); consume = 1'b0;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ce_empty got=%b exp=0", valid); end
      man_ack = 1'b1; man_data = 8'hC3; tick(); man_ack = 1'b0;
      checks++; if ({valid, instruction, head_pc, mem_addr} !== {1'b1, 8'hC3, 16'h0000, 16'h0001}) begin
         failures++; $display("FAIL ce_one got v=%b ins=%h pc=%h addr=%h exp 1 C3 0000 0001", valid, instruction, head_pc, mem_addr);
      end
      consume = 1'b1; tick(); consume = 1'b0;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ce_no_underflow got=%b exp=0", valid); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_consume_one();
      test_flush_wrap();
      test_back_to_back_flush();
      test_pushpop_last();
      test_pushpop_one();
      test_latency();
      test_flush_ack_consume();
      test_rst_mid();
      test_consume_empty();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
